// File: rtl/capture_seq_pkg.sv
// capture_seq_pkg
//   Shared definitions for the RF capture sequencer: default widths,
//   the RELEASE timeout limit, the 3-bit state encoding and a helper
//   that sizes the shared state counter.
package capture_seq_pkg;

  localparam int DLY_W   = 8;
  localparam int LEN_W   = 6;
  localparam int FCNT_W  = 16;
  localparam int TMO_CYC = 15;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_ARMED   = 3'd1;
  localparam logic [2:0] ENC_SETTLE  = 3'd2;
  localparam logic [2:0] ENC_SHIFT   = 3'd3;
  localparam logic [2:0] ENC_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_ARMED   = ENC_ARMED,
    ST_SETTLE  = ENC_SETTLE,
    ST_SHIFT   = ENC_SHIFT,
    ST_RELEASE = ENC_RELEASE
  } state_t;

  // The one counter serves settle, shift and timeout phases, so it must
  // be wide enough for the largest of the three terminal values.
  function automatic int cnt_width(int dly_w, int len_w, int tmo);
    int w;
    w = (dly_w > len_w) ? dly_w : len_w;
    if ($clog2(tmo + 1) > w) w = $clog2(tmo + 1);
    return w;
  endfunction

endpackage

// File: rtl/load_cnt.sv
// load_cnt
//   Loadable up-counter with terminal-count compare.
//   clk, rst : clock and synchronous active-high reset
//   load     : restart the count at 0 on the next edge
//   en       : advance the count by one
//   term     : terminal value to compare against
//   cnt      : current count
//   tc       : high while cnt equals term
module load_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Load wins over enable so every phase starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + W'(1);
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/capture_seq.sv
// capture_seq
//   Sequences one capture frame: waits for the capture FSM to go ACTIVE,
//   settles, shifts the word out with sh_en, then waits for the capture
//   FSM to return to IDLE.
//   clk, rst   : clock and synchronous active-high reset
//   arm        : level enable for sequencing
//   active     : capture FSM is in ACTIVE
//   cfg_delay  : settle cycles before the first sh_en
//   cfg_len    : number of sh_en cycles (0 behaves as 1)
//   sh_en      : shift enable to the capture FSM / shift register
//   bit_idx    : index of the current shift cycle, 0 outside SHIFT
//   busy       : frame in progress (SETTLE, SHIFT, RELEASE)
//   done       : one-cycle pulse on successful frame completion
//   timeout    : sticky, active failed to fall in RELEASE
//   frame_cnt  : completed frame count, wraps
module capture_seq #(
  parameter int DLY_W   = capture_seq_pkg::DLY_W,
  parameter int LEN_W   = capture_seq_pkg::LEN_W,
  parameter int TMO_CYC = capture_seq_pkg::TMO_CYC,
  parameter int FCNT_W  = capture_seq_pkg::FCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              active,
  input  logic [DLY_W-1:0]  cfg_delay,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              sh_en,
  output logic [LEN_W-1:0]  bit_idx,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [FCNT_W-1:0] frame_cnt
);

  import capture_seq_pkg::*;

  localparam int CNT_W = cnt_width(DLY_W, LEN_W, TMO_CYC);

  state_t state, next_state;

  logic [DLY_W-1:0] lat_delay;
  logic [LEN_W-1:0] lat_len;
  logic [CNT_W-1:0] cnt, cnt_term;
  logic             cnt_tc, cnt_load;
  logic             latch_cfg, done_d, timeout_d;

  load_cnt #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (1'b1),
    .term (cnt_term),
    .cnt  (cnt),
    .tc   (cnt_tc)
  );

  // Every state change restarts the shared counter, so each phase
  // counts from zero against its own terminal value.
  assign cnt_load = (next_state != state);

  always_comb begin
    cnt_term = '0;
    case (state)
      ST_SETTLE:  cnt_term = CNT_W'(lat_delay) - CNT_W'(1);
      ST_SHIFT:   cnt_term = CNT_W'(lat_len) - CNT_W'(1);
      ST_RELEASE: cnt_term = CNT_W'(TMO_CYC - 1);
      default:    cnt_term = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Disarm only aborts before shifting starts; once SHIFT begins the
  // frame runs to completion so the capture FSM is always released.
  always_comb begin
    next_state = state;
    latch_cfg  = 1'b0;
    done_d     = 1'b0;
    timeout_d  = timeout;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          next_state = ST_ARMED;
          timeout_d  = 1'b0;
        end
      end
      ST_ARMED: begin
        if (!arm) begin
          next_state = ST_IDLE;
        end else if (active) begin
          latch_cfg  = 1'b1;
          next_state = (cfg_delay == '0) ? ST_SHIFT : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!arm)        next_state = ST_IDLE;
        else if (cnt_tc) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_tc) next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!active) begin
          done_d     = 1'b1;
          next_state = arm ? ST_ARMED : ST_IDLE;
        end else if (cnt_tc) begin
          timeout_d  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with
  // the state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en     <= 1'b0;
      bit_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      frame_cnt <= '0;
      lat_delay <= '0;
      lat_len   <= '0;
    end else begin
      sh_en   <= (next_state == ST_SHIFT);
      busy    <= (next_state == ST_SETTLE) || (next_state == ST_SHIFT) ||
                 (next_state == ST_RELEASE);
      done    <= done_d;
      timeout <= timeout_d;
      if (next_state == ST_SHIFT)
        bit_idx <= cnt_load ? '0 : LEN_W'(cnt + CNT_W'(1));
      else
        bit_idx <= '0;
      if (done_d)
        frame_cnt <= frame_cnt + FCNT_W'(1);
      if (latch_cfg) begin
        lat_delay <= cfg_delay;
        lat_len   <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
      end
    end
  end

endmodule

// File: doc/capture_seq.md
# capture_seq

Sequencer for the RF capture front end. While armed, it waits for the capture FSM to report ACTIVE after an `rfin` event. It then waits a programmable settle time and drives `sh_en` high for a programmable number of cycles to shift the captured word out. Finally it confirms that the capture FSM has returned to IDLE, which that FSM does on the falling edge of `sh_en`. The block sits between the capture FSM's `state` output and its `sh_en` input, and reports frame completion and faults to the readout logic.

## Interface
- DLY_W, 8: width of settle-delay config.
- LEN_W, 6: width of shift-length config.
- TMO_CYC, 15: maximum cycles allowed in RELEASE for `active` to fall.
- FCNT_W, 16: width of frame counter.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- arm  in  1  enable sequencing; level.
- active  in  1  capture FSM state (1 = ACTIVE); synchronous to clk.
- cfg_delay  in  DLY_W  settle cycles between ACTIVE detection and first `sh_en`.
- cfg_len  in  LEN_W  number of `sh_en` cycles; 0 is treated as 1.
- sh_en  out  1  shift enable to capture FSM / shift register; registered.
- bit_idx  out  LEN_W  index of the current shift cycle, 0..len-1; 0 outside SHIFT.
- busy  out  1  high in SETTLE, SHIFT and RELEASE.
- done  out  1  one-cycle pulse on successful frame completion.
- timeout  out  1  sticky fault: `active` did not fall within TMO_CYC cycles.
- frame_cnt  out  FCNT_W  count of completed frames; wraps modulo 2^FCNT_W.

## Operation
- States: IDLE, ARMED, SETTLE, SHIFT, RELEASE.
- **IDLE**
  - `arm`=1 → ARMED.
  - On this transition, clear `timeout`.
- **ARMED**
  - `arm`=0 → IDLE.
  - `active`=1 → SETTLE, or SHIFT if `cfg_delay`=0.
  - Latch `cfg_delay` and `cfg_len` here. Config changes mid-frame have no effect.
- **SETTLE**
  - Count the latched delay; after the last settle cycle → SHIFT.
  - `arm`=0 → IDLE immediately; `sh_en` is never asserted.
- **SHIFT**
  - `sh_en`=1 for exactly `len` cycles; `bit_idx` increments 0..len-1.
  - Then → RELEASE.
  - `arm` is ignored; the frame always completes so the capture FSM can be released.
- **RELEASE**
  - `sh_en`=0. Counter runs from 0.
  - `active` sampled 0 → pulse `done`, increment `frame_cnt`, then:
    - → ARMED if `arm`=1,
    - → IDLE if `arm`=0.
  - Counter reaches TMO_CYC with `active` still 1 → set `timeout`, → IDLE. No `done`, no count.
- `active` already 1 on entry to ARMED (stale capture): this is treated as a fresh event, and the frame proceeds.
- `frame_cnt` wraps from all-ones to 0 without a flag.

## Timing
- Reset values:
  - state IDLE;
  - `sh_en`, `busy`, `done`, `timeout` = 0;
  - `bit_idx` = 0;
  - `frame_cnt` = 0;
  - internal counters = 0.
- All outputs are registered.
- `active`=1 sampled in ARMED at cycle T:
  - `busy` rises at T+1;
  - first `sh_en`=1 at T+1+D, where D is the latched delay;
  - last `sh_en`=1 at T+D+L.
- The capture FSM de-asserts `active` about 3 cycles after the `sh_en` fall (2-flop sync plus edge detect). `done` goes high the cycle after `active`=0 is sampled in RELEASE.
- `busy` falls in the same cycle `done` rises.
- `done` is never high in two consecutive cycles.
- Back-to-back frames are allowed: earliest re-detection is the cycle after `done`.
- `rst` mid-frame drops `sh_en` on the next edge. `frame_cnt` and `timeout` are cleared.

## Structure
- Package `capture_seq_pkg` holds:
  - state encoding localparams (3-bit);
  - default widths DLY_W, LEN_W, FCNT_W;
  - TMO_CYC.
- Sub-module `load_cnt`: loadable up-counter with terminal-count compare. One instance is shared by SETTLE, SHIFT and RELEASE, reloaded on each state entry.
- Top module holds the FSM, output registers and `frame_cnt`. Expected size is about 150–250 RTL lines.

## Test plan
- Nominal frame: `arm`=1, D=4, L=8, `active` rises at T and falls 3 cycles after `sh_en` falls.
  - Expect: `sh_en` high T+5..T+12; `bit_idx` 0..7; one `done`; `frame_cnt`=1.
- Zero config: D=0, L=0.
  - Expect: `sh_en` high for exactly 1 cycle, at T+1.
- Timeout: `active` held 1 permanently.
  - Expect: 15 cycles after RELEASE entry, `timeout`=1 and state IDLE, no `done`, `frame_cnt` unchanged.
  - Then `arm` 0→1 clears `timeout`.
- Disarm cases:
  - `arm` dropped during SETTLE → `sh_en` never rises and state IDLE.
  - `arm` dropped at the 3rd SHIFT cycle (L=8) → all 8 `sh_en` cycles still occur, then `done`, then IDLE.
- Mid-frame reset: `rst` asserted during SHIFT with `frame_cnt`=5.
  - Expect: next cycle `sh_en`=0 and `frame_cnt`=0.
- Wrap and back-to-back: preload 65535 frames (or FCNT_W=4 with 16 frames), each with `active` re-rising the cycle after `done`.
  - Expect: `frame_cnt` wraps to 0 and no `done` pulses are missed.
